fp_mul_pipe: RTL and testbench
==============================

# fp_mul_pipe

Parametrised, pipelined IEEE-754 binary floating-point multiplier with a valid/ready handshake on both sides. It sits in the FPU datapath next to the adder and issues one product per cycle at full throughput. It supersedes the single-cycle FP32 multiplier: any exponent/mantissa width, correct guard/round/sticky rounding in four modes, NaN/infinity/zero/subnormal handling, and full exception flags.

## Interface
- EXP_W, 8, exponent field width (≥3)
- MAN_W, 23, stored fraction width (≥2); word width W = 1+EXP_W+MAN_W
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand pair and mode present
- in_ready  out  1  pipeline accepts this cycle
- a, b  in  W  operands {sign, exp, frac}
- round_mode  in  2  00 toward +inf, 01 toward −inf, 10 nearest-even, 11 nearest ties-away
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts
- result  out  W  product
- overflow, underflow, inexact, invalid  out  1 each  flags, qualified by out_valid
- error  out  1  overflow | invalid

## Operation
- Bias = 2^(EXP_W−1)−1. Exponent arithmetic uses signed EXP_W+2 bits; no wrap.
- Input classes: exp==0 → zero, with subnormals flushed to signed zero and no flag; exp all-ones, frac==0 → inf; exp all-ones, frac≠0 → NaN.
- Sign = sa^sb for every non-NaN result.
- Priority order:
  - Any NaN operand → canonical qNaN {0, all-ones, 1 then zeros}. invalid=1 only if that NaN is signalling (frac MSB 0).
  - inf×0 → qNaN, invalid=1.
  - inf×x → signed inf, no flags.
  - 0×x → signed zero, no flags.
- Finite path:
  - P = {1,fa}×{1,fb}, 2·(MAN_W+1) bits, value in [1,4).
  - If P MSB set: shift right 1, exp+1.
  - e = ea+eb−bias(+1).
  - Keep MAN_W+1 bits. G = next bit, R = bit after, S = OR of the rest.
  - inexact = G|R|S.
- Round increment by mode:
  - 10: G&(R|S|lsb).
  - 11: G.
  - 00: ~sign & (G|R|S).
  - 01: sign & (G|R|S).
  - A mantissa carry-out renormalises with exp+1.
- Overflow (e ≥ 2^EXP_W−1 after rounding): overflow=1, inexact=1.
  - Result is signed inf for modes 10/11 and for rounding toward the sign.
  - Otherwise result is signed max-finite {exp all-ones−1, frac all-ones}.
- Underflow (e ≤ 0 after rounding): signed zero, underflow=1, inexact=1. No subnormal outputs.

## Timing
- Three stages, latency 3 cycles from accepted input to out_valid, throughput 1/cycle.
  - S1: classify, exponent sum, special-result select.
  - S2: mantissa multiply.
  - S3: normalise, round, pack, flags.
- Global stall: adv = ~out_valid | out_ready. Then in_ready = adv.
- On adv, every stage register loads its predecessor. An empty stage carries valid=0.
- Transfer in occurs on in_valid & in_ready. Transfer out occurs on out_valid & out_ready.
- While stalled, result, flags and out_valid hold stable. Inputs with in_ready=0 are not captured.
- Results leave in issue order. No drops, no duplicates.
- Simultaneous out transfer and in transfer in the same cycle is legal: full throughput with no bubble.
- Reset (rst_n=0 at an edge) clears all stage valids, including mid-flight data, which is discarded.
  - Reset values: out_valid=0, result=0, every flag=0, error=0.
  - in_ready=1 in the first cycle after reset.

## Structure
- Shared package fp_pkg holds:
  - the round-mode enum,
  - the flag struct {overflow, underflow, inexact, invalid},
  - class encoding (zero/inf/nan/normal),
  - functions for bias, canonical qNaN and max-finite, parametrised by EXP_W/MAN_W.
- One sub-module, fp_round_pack: combinational S3 logic (normalise, G/R/S, mode increment, overflow/underflow selection, pack). The adder will reuse it.

## Test plan
- 0x3FC00000 × 0x40000000, mode 10 → 0x40400000, all flags 0, out_valid exactly 3 cycles after accept.
- 0x3F800001 × 0x3F800001:
  - mode 10 → 0x3F800002, inexact=1.
  - mode 00 → 0x3F800003.
  - mode 01 → 0x3F800002.
- 0x7F800000 × 0x00000000 → 0x7FC00000, invalid=1, error=1. 0x7FA00000 × 0x3F800000 → 0x7FC00000, invalid=1.
- 0x7F000000 × 0x7F000000:
  - mode 10 → 0x7F800000, overflow=1, error=1.
  - mode 01 → 0x7F7FFFFF.
  - 0x00800000 × 0x00800000 → 0x00000000, underflow=1.
- Issue 8 back-to-back products with out_ready low for cycles 4–8 → in_ready drops when full, all 8 results emerge in order, outputs stable during stall.
- Assert rst_n low for 1 cycle with 3 items in flight → out_valid=0 next cycle, no stale result ever appears. Rerun with EXP_W=5, MAN_W=10: 0x3E00 × 0x4000 → 0x4200.

Source files
------------

// File: rtl/fp_mul_pipe_pkg.sv
// Shared FP definitions: rounding modes, exception flags, operand classes and
// format constants usable by any FP unit regardless of EXP_W/MAN_W.
package fp_pkg;

  typedef enum logic [1:0] {
    RM_UP   = 2'b00,
    RM_DOWN = 2'b01,
    RM_RNE  = 2'b10,
    RM_RNA  = 2'b11
  } round_mode_e;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
    logic invalid;
  } fp_flags_t;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_INF,
    CLS_NAN,
    CLS_NORM
  } fp_class_e;

  localparam int MAX_W = 64;

  function automatic int fp_bias(input int expW);
    return (1 << (expW - 1)) - 1;
  endfunction

  // Subnormals share exp==0 with zero and are deliberately flushed.
  function automatic fp_class_e fp_classify(input logic expZero, input logic expOnes,
                                            input logic fracZero);
    if (expZero) return CLS_ZERO;
    if (expOnes) return fracZero ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

  function automatic logic [MAX_W-1:0] fp_qnan(input int expW, input int manW);
    logic [MAX_W-1:0] w;
    w = '0;
    for (int i = 0; i < expW; i++) w[manW+i] = 1'b1;
    w[manW-1] = 1'b1;
    return w;
  endfunction

  function automatic logic [MAX_W-1:0] fp_max_finite(input int expW, input int manW);
    logic [MAX_W-1:0] w;
    w = '0;
    for (int i = 0; i < expW + manW; i++) w[i] = (i != manW);
    return w;
  endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// Handshake and data bundle for the FP multiplier: operand side and result side.
interface fp_mul_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   round_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         overflow;
  logic         underflow;
  logic         inexact;
  logic         invalid;
  logic         error;

  modport slave (
    input  in_valid, a, b, round_mode, out_ready,
    output in_ready, out_valid, result, overflow, underflow, inexact, invalid, error
  );

  modport master (
    output in_valid, a, b, round_mode, out_ready,
    input  in_ready, out_valid, result, overflow, underflow, inexact, invalid, error
  );
endinterface

// File: rtl/fp_mul_pipe_round_pack.sv
// Normalise a [1,4) significand product, round with G/R/S in the requested mode,
// and pack with overflow/underflow saturation. Purely combinational.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     sign_i,
  input  logic signed [EXP_W+1:0]  exp_i,
  input  logic [2*MAN_W+1:0]       prod_i,
  input  round_mode_e              mode_i,
  output logic [EXP_W+MAN_W:0]     result_o,
  output fp_flags_t                flags_o
);
  localparam int MW1 = MAN_W + 1;
  localparam int PW  = 2 * MW1;
  localparam int EW2 = EXP_W + 2;
  localparam int WM  = EXP_W + MAN_W;
  localparam logic signed [EW2-1:0] EXP_MAX = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] EXP_ONE = EW2'(1);
  localparam logic [WM-1:0] MAXF = WM'(fp_max_finite(EXP_W, MAN_W));

  logic                  msb;
  logic [PW-1:0]         normP;
  logic [MAN_W:0]        mant;
  logic                  g, r, s, inc, carry, toInf;
  logic [MAN_W+1:0]      mantR;
  logic [MAN_W-1:0]      frac;
  logic signed [EW2-1:0] expR;

  always_comb begin
    msb   = prod_i[PW-1];
    normP = msb ? prod_i : (prod_i << 1);
    mant  = normP[PW-1 -: MW1];
    g     = normP[PW-MW1-1];
    r     = normP[PW-MW1-2];
    s     = |normP[PW-MW1-3:0];
    inc   = 1'b0;
    case (mode_i)
      RM_RNE:  inc = g & (r | s | mant[0]);
      RM_RNA:  inc = g;
      RM_UP:   inc = ~sign_i & (g | r | s);
      default: inc = sign_i & (g | r | s);
    endcase
    // A carry out of the significand leaves 1.000..0, so the fraction is all zeros.
    mantR = {1'b0, mant} + (MAN_W+2)'(inc);
    carry = mantR[MAN_W+1];
    frac  = carry ? mantR[MAN_W:1] : mantR[MAN_W-1:0];
    expR  = exp_i + EW2'(msb) + EW2'(carry);
    toInf = (mode_i == RM_RNE) || (mode_i == RM_RNA) ||
            (mode_i == RM_UP && !sign_i) || (mode_i == RM_DOWN && sign_i);

    flags_o         = '0;
    flags_o.inexact = g | r | s;
    result_o        = {sign_i, EXP_W'(expR), frac};
    if (expR >= EXP_MAX) begin
      flags_o.overflow = 1'b1;
      flags_o.inexact  = 1'b1;
      result_o = toInf ? {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {sign_i, MAXF};
    end else if (expR < EXP_ONE) begin
      flags_o.underflow = 1'b1;
      flags_o.inexact   = 1'b1;
      result_o = {sign_i, {WM{1'b0}}};
    end
  end
endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-754 multiplier: S1 classify/exponent, S2 significand multiply,
// S3 round/pack. One global advance signal stalls every stage together.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic          clk,
  input  logic          rst_n,
  fp_mul_pipe_if.slave  bus
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int EW2 = EXP_W + 2;
  localparam int MW1 = MAN_W + 1;
  localparam int PW  = 2 * MW1;
  localparam logic [W-1:0] QNAN = W'(fp_qnan(EXP_W, MAN_W));
  localparam logic signed [EW2-1:0] BIAS = EW2'(fp_bias(EXP_W));

  logic                  adv;
  logic                  signA, signB;
  logic [EXP_W-1:0]      expA, expB;
  logic [MAN_W-1:0]      fracA, fracB;
  fp_class_e             clsA, clsB;

  logic                  special1_d, specInv1_d, sign1_d;
  logic [W-1:0]          specRes1_d;
  logic signed [EW2-1:0] exp1_d;

  logic                  valid1_q, sign1_q, special1_q, specInv1_q;
  logic [W-1:0]          specRes1_q;
  logic signed [EW2-1:0] exp1_q;
  logic [MAN_W:0]        mA1_q, mB1_q;
  round_mode_e           mode1_q;

  logic                  valid2_q, sign2_q, special2_q, specInv2_q;
  logic [W-1:0]          specRes2_q;
  logic signed [EW2-1:0] exp2_q;
  logic [PW-1:0]         prod2_q;
  round_mode_e           mode2_q;

  logic [W-1:0]          rpResult, result_d, result_q;
  fp_flags_t             rpFlags, flags_d, flags_q;
  logic                  outValid_q;

  assign adv          = ~outValid_q | bus.out_ready;
  assign bus.in_ready = adv;

  assign {signA, expA, fracA} = bus.a;
  assign {signB, expB, fracB} = bus.b;
  assign clsA = fp_classify(expA == '0, &expA, fracA == '0);
  assign clsB = fp_classify(expB == '0, &expB, fracB == '0);

  // Special operands resolve entirely in S1; the finite path is ignored downstream.
  always_comb begin
    sign1_d    = signA ^ signB;
    special1_d = 1'b1;
    specInv1_d = 1'b0;
    specRes1_d = QNAN;
    exp1_d     = $signed({2'b00, expA}) + $signed({2'b00, expB}) - BIAS;
    if (clsA == CLS_NAN || clsB == CLS_NAN) begin
      specInv1_d = (clsA == CLS_NAN && !fracA[MAN_W-1]) || (clsB == CLS_NAN && !fracB[MAN_W-1]);
    end else if ((clsA == CLS_INF && clsB == CLS_ZERO) || (clsA == CLS_ZERO && clsB == CLS_INF)) begin
      specInv1_d = 1'b1;
    end else if (clsA == CLS_INF || clsB == CLS_INF) begin
      specRes1_d = {sign1_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (clsA == CLS_ZERO || clsB == CLS_ZERO) begin
      specRes1_d = {sign1_d, {(W-1){1'b0}}};
    end else begin
      special1_d = 1'b0;
    end
  end

  fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_pack (
    .sign_i   (sign2_q),
    .exp_i    (exp2_q),
    .prod_i   (prod2_q),
    .mode_i   (mode2_q),
    .result_o (rpResult),
    .flags_o  (rpFlags)
  );

  always_comb begin
    result_d = '0;
    flags_d  = '0;
    if (valid2_q) begin
      if (special2_q) begin
        result_d        = specRes2_q;
        flags_d.invalid = specInv2_q;
      end else begin
        result_d = rpResult;
        flags_d  = rpFlags;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid1_q   <= 1'b0;
      valid2_q   <= 1'b0;
      outValid_q <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
    end else if (adv) begin
      valid1_q   <= bus.in_valid;
      valid2_q   <= valid1_q;
      outValid_q <= valid2_q;
      result_q   <= result_d;
      flags_q    <= flags_d;
    end
  end

  // Payload registers carry no reset; their valid bits qualify them.
  always_ff @(posedge clk) begin
    if (adv) begin
      sign1_q    <= sign1_d;
      special1_q <= special1_d;
      specInv1_q <= specInv1_d;
      specRes1_q <= specRes1_d;
      exp1_q     <= exp1_d;
      mA1_q      <= {1'b1, fracA};
      mB1_q      <= {1'b1, fracB};
      mode1_q    <= round_mode_e'(bus.round_mode);
      sign2_q    <= sign1_q;
      special2_q <= special1_q;
      specInv2_q <= specInv1_q;
      specRes2_q <= specRes1_q;
      exp2_q     <= exp1_q;
      prod2_q    <= PW'(mA1_q) * PW'(mB1_q);
      mode2_q    <= mode1_q;
    end
  end

  assign bus.out_valid = outValid_q;
  assign bus.result    = result_q;
  assign bus.overflow  = flags_q.overflow;
  assign bus.underflow = flags_q.underflow;
  assign bus.inexact   = flags_q.inexact;
  assign bus.invalid   = flags_q.invalid;
  assign bus.error     = flags_q.overflow | flags_q.invalid;
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe: FP32 instance for rounding, specials, overflow,
// stall and reset flush; a half-precision instance for width parametrisation.
module tb_fp_mul_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vecCount = 0;
  int   missCount = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  rm;
    logic [31:0] res;
    logic [3:0]  fl;
  } vec_t;

  always #5 clk = ~clk;

  fp_mul_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();
  fp_mul_pipe_if #(.EXP_W(5), .MAN_W(10)) hbus ();

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dutHalf (.clk(clk), .rst_n(rst_n), .bus(hbus));

  // Issues one operand pair into an empty pipe and collects its result; flags are {ov,un,inx,inv}.
  task automatic run_one(input logic [31:0] av, input logic [31:0] bv, input logic [1:0] rm,
                         output logic [31:0] res, output logic [3:0] fl, output logic err,
                         output int lat);
    bus.a = av; bus.b = bv; bus.round_mode = rm;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result;
    fl  = {bus.overflow, bus.underflow, bus.inexact, bus.invalid};
    err = bus.error;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vecCount++;
    if (bus.out_valid !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL reset_valid: out_valid %b, required 0", bus.out_valid);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vecCount++;
    if (bus.in_ready !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL reset_in_ready: in_ready %b, required 1", bus.in_ready);
    end
    vecCount++;
    if (bus.result !== 32'h0 || {bus.overflow, bus.underflow, bus.inexact, bus.invalid, bus.error} !== 5'b0) begin
      missCount++;
      $display("[TB] FAIL reset_outputs: result %h flags+err %b, required 00000000 00000",
               bus.result, {bus.overflow, bus.underflow, bus.inexact, bus.invalid, bus.error});
    end
  endtask

  task automatic test_latency();
    logic [31:0] res; logic [3:0] fl; logic err; int lat;
    run_one(32'h3FC00000, 32'h40000000, 2'b10, res, fl, err, lat);
    vecCount++;
    if (lat != 3) begin
      missCount++;
      $display("[TB] FAIL latency: %0d cycles, required 3", lat);
    end
    vecCount++;
    if (res !== 32'h40400000 || fl !== 4'b0000 || err !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL latency_value: result %h flags %b err %b, required 40400000 0000 0", res, fl, err);
    end
  endtask

  task automatic test_rounding();
    logic [31:0] res; logic [3:0] fl; logic err; int lat;
    vec_t tbl [11] = '{
      '{32'h3F800001, 32'h3F800001, 2'b10, 32'h3F800002, 4'b0010},
      '{32'h3F800001, 32'h3F800001, 2'b00, 32'h3F800003, 4'b0010},
      '{32'h3F800001, 32'h3F800001, 2'b01, 32'h3F800002, 4'b0010},
      '{32'h3F800003, 32'h3FC00000, 2'b10, 32'h3FC00004, 4'b0010},
      '{32'h3F800003, 32'h3FC00000, 2'b11, 32'h3FC00005, 4'b0010},
      '{32'h3FC00000, 32'h3FC00000, 2'b10, 32'h40100000, 4'b0000},
      '{32'h3FFFFFFF, 32'h3FFFFFFF, 2'b10, 32'h407FFFFE, 4'b0010},
      '{32'h3FFFFFFF, 32'h3FFFFFFF, 2'b00, 32'h407FFFFF, 4'b0010},
      '{32'hBFC00000, 32'h40000000, 2'b10, 32'hC0400000, 4'b0000},
      '{32'hBF800001, 32'h3F800001, 2'b01, 32'hBF800003, 4'b0010},
      '{32'hBF800001, 32'h3F800001, 2'b00, 32'hBF800002, 4'b0010}
    };
    foreach (tbl[i]) begin
      run_one(tbl[i].a, tbl[i].b, tbl[i].rm, res, fl, err, lat);
      vecCount++;
      if (res !== tbl[i].res || fl !== tbl[i].fl || err !== (tbl[i].fl[3] | tbl[i].fl[0]) || lat != 3) begin
        missCount++;
        $display("[TB] FAIL rounding[%0d]: result %h flags %b err %b lat %0d, required %h %b %b lat 3",
                 i, res, fl, err, lat, tbl[i].res, tbl[i].fl, tbl[i].fl[3] | tbl[i].fl[0]);
      end
    end
  endtask

  task automatic test_specials();
    logic [31:0] res; logic [3:0] fl; logic err; int lat;
    vec_t tbl [7] = '{
      '{32'h7F800000, 32'h00000000, 2'b10, 32'h7FC00000, 4'b0001},
      '{32'h7FA00000, 32'h3F800000, 2'b10, 32'h7FC00000, 4'b0001},
      '{32'h7FC00001, 32'h3F800000, 2'b10, 32'h7FC00000, 4'b0000},
      '{32'hFFC00000, 32'h00000000, 2'b01, 32'h7FC00000, 4'b0000},
      '{32'hFF800000, 32'h40000000, 2'b10, 32'hFF800000, 4'b0000},
      '{32'h00000000, 32'hC0000000, 2'b10, 32'h80000000, 4'b0000},
      '{32'h00000001, 32'h3F800000, 2'b00, 32'h00000000, 4'b0000}
    };
    foreach (tbl[i]) begin
      run_one(tbl[i].a, tbl[i].b, tbl[i].rm, res, fl, err, lat);
      vecCount++;
      if (res !== tbl[i].res || fl !== tbl[i].fl || err !== (tbl[i].fl[3] | tbl[i].fl[0]) || lat != 3) begin
        missCount++;
        $display("[TB] FAIL special[%0d]: result %h flags %b err %b lat %0d, required %h %b %b lat 3",
                 i, res, fl, err, lat, tbl[i].res, tbl[i].fl, tbl[i].fl[3] | tbl[i].fl[0]);
      end
    end
  endtask

  task automatic test_range();
    logic [31:0] res; logic [3:0] fl; logic err; int lat;
    vec_t tbl [12] = '{
      '{32'h7F000000, 32'h7F000000, 2'b10, 32'h7F800000, 4'b1010},
      '{32'h7F000000, 32'h7F000000, 2'b01, 32'h7F7FFFFF, 4'b1010},
      '{32'h7F000000, 32'h7F000000, 2'b00, 32'h7F800000, 4'b1010},
      '{32'h7F000000, 32'h7F000000, 2'b11, 32'h7F800000, 4'b1010},
      '{32'hFF000000, 32'h7F000000, 2'b00, 32'hFF7FFFFF, 4'b1010},
      '{32'hFF000000, 32'h7F000000, 2'b01, 32'hFF800000, 4'b1010},
      '{32'h7F000000, 32'h40000000, 2'b10, 32'h7F800000, 4'b1010},
      '{32'h7E800000, 32'h40000000, 2'b10, 32'h7F000000, 4'b0000},
      '{32'h00800000, 32'h00800000, 2'b10, 32'h00000000, 4'b0110},
      '{32'h80800000, 32'h00800000, 2'b10, 32'h80000000, 4'b0110},
      '{32'h00800000, 32'h3F800000, 2'b10, 32'h00800000, 4'b0000},
      '{32'h00800000, 32'h3F000000, 2'b10, 32'h00000000, 4'b0110}
    };
    foreach (tbl[i]) begin
      run_one(tbl[i].a, tbl[i].b, tbl[i].rm, res, fl, err, lat);
      vecCount++;
      if (res !== tbl[i].res || fl !== tbl[i].fl || err !== (tbl[i].fl[3] | tbl[i].fl[0]) || lat != 3) begin
        missCount++;
        $display("[TB] FAIL range[%0d]: result %h flags %b err %b lat %0d, required %h %b %b lat 3",
                 i, res, fl, err, lat, tbl[i].res, tbl[i].fl, tbl[i].fl[3] | tbl[i].fl[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ops [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic [31:0] expRes [8] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
                                32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};
    int  sent = 0;
    int  recv = 0;
    logic stall;
    for (int cyc = 1; cyc <= 60 && recv < 8; cyc++) begin
      stall        = (cyc >= 4 && cyc <= 8);
      bus.in_valid = (sent < 8);
      bus.a        = ops[(sent < 8) ? sent : 7];
      bus.b        = 32'h40000000;
      bus.round_mode = 2'b10;
      bus.out_ready  = !stall;
      #1;
      if (bus.out_valid || stall) begin
        vecCount++;
        if (bus.out_valid !== 1'b1 || bus.result !== expRes[recv] || (stall && bus.in_ready !== 1'b0)) begin
          missCount++;
          $display("[TB] FAIL b2b_out[%0d] cycle %0d: valid %b result %h in_ready %b, required valid 1 result %h in_ready %b",
                   recv, cyc, bus.out_valid, bus.result, bus.in_ready, expRes[recv], !stall);
        end
        if (!stall) recv++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      if (cyc == 8) begin
        vecCount++;
        if (sent != 3) begin
          missCount++;
          $display("[TB] FAIL b2b_fill: %0d accepted by end of stall, required 3", sent);
        end
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    vecCount++;
    if (recv != 8 || sent != 8) begin
      missCount++;
      $display("[TB] FAIL b2b_count: sent %0d received %0d, required 8 and 8", sent, recv);
    end
  endtask

  task automatic test_reset_flush();
    logic [31:0] res; logic [3:0] fl; logic err; int lat;
    logic sawValid = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.a = 32'h40400000; bus.b = 32'h40400000; bus.round_mode = 2'b10;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    vecCount++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL flush_valid: out_valid %b in_ready %b, required 0 1", bus.out_valid, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid) sawValid = 1'b1;
      @(posedge clk); #1;
    end
    vecCount++;
    if (sawValid !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL flush_stale: stale out_valid %b after reset, required 0", sawValid);
    end
    run_one(32'h40400000, 32'h40400000, 2'b10, res, fl, err, lat);
    vecCount++;
    if (res !== 32'h41100000 || fl !== 4'b0000 || lat != 3) begin
      missCount++;
      $display("[TB] FAIL flush_resume: result %h flags %b lat %0d, required 41100000 0000 lat 3", res, fl, lat);
    end
  endtask

  task automatic test_half();
    logic [15:0] ha [2] = '{16'h3E00, 16'h7800};
    logic [15:0] hb [2] = '{16'h4000, 16'h4000};
    logic [15:0] hr [2] = '{16'h4200, 16'h7C00};
    logic [3:0]  hf [2] = '{4'b0000, 4'b1010};
    logic [3:0]  fl;
    int lat;
    for (int i = 0; i < 2; i++) begin
      hbus.a = ha[i]; hbus.b = hb[i]; hbus.round_mode = 2'b10;
      hbus.in_valid = 1'b1; hbus.out_ready = 1'b1;
      @(posedge clk); #1;
      hbus.in_valid = 1'b0;
      lat = 1;
      while (!hbus.out_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      fl = {hbus.overflow, hbus.underflow, hbus.inexact, hbus.invalid};
      vecCount++;
      if (hbus.result !== hr[i] || fl !== hf[i] || lat != 3) begin
        missCount++;
        $display("[TB] FAIL half[%0d]: result %h flags %b lat %0d, required %h %b lat 3",
                 i, hbus.result, fl, lat, hr[i], hf[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.a = '0; bus.b = '0; bus.round_mode = 2'b10;
    hbus.in_valid = 1'b0; hbus.out_ready = 1'b1; hbus.a = '0; hbus.b = '0; hbus.round_mode = 2'b10;
    test_reset();
    test_latency();
    test_rounding();
    test_specials();
    test_range();
    test_back_to_back();
    test_reset_flush();
    test_half();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule
